// File: rtl/smart_key_arbiter_if.sv
// Key-memory port bundle: CPU single-word reads, MAC burst reads and the shared memory bus.
// slave = arbiter side, master = requesters plus memory.
interface smart_key_arbiter_if #(
   parameter int SIZE_MEM_ADDR = 5
);
   logic                     cpu_req;
   logic [SIZE_MEM_ADDR-1:0] cpu_addr;
   logic [15:0]              cpu_rdata;
   logic                     cpu_ack;

   logic                     mac_start;
   logic [SIZE_MEM_ADDR-1:0] mac_addr;
   logic [15:0]              mac_rdata;
   logic                     mac_valid;
   logic                     mac_done;

   logic [SIZE_MEM_ADDR-1:0] mem_addr;
   logic                     mem_rd;
   logic [15:0]              mem_dout;

   modport slave (
      input  cpu_req, cpu_addr, mac_start, mac_addr, mem_dout,
      output cpu_rdata, cpu_ack, mac_rdata, mac_valid, mac_done, mem_addr, mem_rd
   );

   modport master (
      output cpu_req, cpu_addr, mac_start, mac_addr, mem_dout,
      input  cpu_rdata, cpu_ack, mac_rdata, mac_valid, mac_done, mem_addr, mem_rd
   );
endinterface

// File: rtl/smart_key_arbiter.sv
// Arbiter/sequencer sharing one synchronous-read key memory between MAC bursts and CPU reads.
// Optional macro SMART_VIOLATION_RESET_EN: a denied CPU read pulses reset and flushes pending work.
module smart_key_arbiter #(
   parameter int SIZE_MEM_ADDR = 5,
   parameter int LOW_CODE      = 16,
   parameter int HIGH_CODE     = 32,
   parameter int LOW_SAFE      = 20,
   parameter int HIGH_SAFE     = 30,
   parameter int MAC_BURST     = 8,
   parameter int RESET_CYCLES  = 4
) (
   input  logic                 mclk,
   input  logic                 reset_n,
   smart_key_arbiter_if.slave   bus,
   input  logic [15:0]          ins_addr,
   output logic                 in_safe_area,
   output logic                 violation,
   output logic                 reset
);
   localparam int AW = SIZE_MEM_ADDR;
   localparam int BW = $clog2(MAC_BURST + 1);
   localparam int RW = $clog2(RESET_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, MAC_RD, CPU_RD, CPU_DENY, CPU_ACK} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic            ok_q, ok_d;
   logic            cpu_pend_q, cpu_pend_d;
   logic [AW-1:0]   cpu_pend_addr_q, cpu_pend_addr_d;
   logic            cpu_pend_ok_q, cpu_pend_ok_d;
   logic            mac_pend_q, mac_pend_d;
   logic [AW-1:0]   mac_pend_addr_q, mac_pend_addr_d;
   logic            viol_q, viol_d;
   logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
   logic            mac_valid_q, mac_valid_d;
   logic            mac_done_q, mac_done_d;
   logic            safe_q, safe_d;

   logic            flush;
   logic            cpu_in, cpu_in_ok, mac_in;
   logic            cpu_vld, mac_vld;
   logic            cpu_sel_ok;
   logic [AW-1:0]   cpu_sel_addr, mac_sel_addr;
   logic            mem_rd_w;

`ifdef SMART_VIOLATION_RESET_EN
   assign flush = (rst_cnt_q != '0);
`else
   assign flush = 1'b0;
`endif

   // ins_addr is judged in the cycle of the pulse, not when the request is serviced
   assign cpu_in_ok = ({1'b0, ins_addr} >= 17'(LOW_CODE)) && ({1'b0, ins_addr} < 17'(HIGH_CODE));
   assign cpu_in    = bus.cpu_req & ~flush;
   assign mac_in    = bus.mac_start & ~flush & (state_q != MAC_RD);

   assign cpu_vld      = ~flush & (cpu_pend_q | cpu_in);
   assign mac_vld      = ~flush & (mac_pend_q | mac_in);
   assign cpu_sel_addr = cpu_pend_q ? cpu_pend_addr_q : bus.cpu_addr;
   assign cpu_sel_ok   = cpu_pend_q ? cpu_pend_ok_q : cpu_in_ok;
   assign mac_sel_addr = mac_pend_q ? mac_pend_addr_q : bus.mac_addr;

   assign safe_d = ({1'b0, ins_addr} >= 17'(LOW_SAFE)) && ({1'b0, ins_addr} < 17'(HIGH_SAFE));

   always_comb begin
      logic mac_take;
      logic cpu_take;
      state_d         = state_q;
      addr_d          = addr_q;
      beat_d          = beat_q;
      ok_d            = ok_q;
      viol_d          = viol_q;
      rst_cnt_d       = (rst_cnt_q != '0) ? rst_cnt_q - RW'(1) : '0;
      mac_valid_d     = (state_q == MAC_RD);
      mac_done_d      = 1'b0;
      cpu_pend_d      = cpu_pend_q;
      cpu_pend_addr_d = cpu_pend_addr_q;
      cpu_pend_ok_d   = cpu_pend_ok_q;
      mac_pend_d      = mac_pend_q;
      mac_pend_addr_d = mac_pend_addr_q;
      mac_take        = 1'b0;
      cpu_take        = 1'b0;

      case (state_q)
         IDLE: begin
            if (mac_vld) begin
               mac_take = 1'b1;
               state_d  = MAC_RD;
               addr_d   = mac_sel_addr;
               beat_d   = '0;
            end else if (cpu_vld) begin
               cpu_take = 1'b1;
               addr_d   = cpu_sel_addr;
               ok_d     = cpu_sel_ok;
               if (cpu_sel_ok) begin
                  state_d = CPU_RD;
               end else begin
                  state_d   = CPU_DENY;
                  viol_d    = 1'b1;
                  rst_cnt_d = RW'(RESET_CYCLES);
               end
            end
         end
         MAC_RD: begin
            addr_d = addr_q + AW'(1);
            beat_d = beat_q + BW'(1);
            if (beat_q == BW'(MAC_BURST - 1)) begin
               mac_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
         CPU_RD, CPU_DENY: state_d = CPU_ACK;
         CPU_ACK:          state_d = IDLE;
         default:          state_d = IDLE;
      endcase

      // a pulse taken straight from IDLE never occupies its entry
      if (flush || mac_take) begin
         mac_pend_d = 1'b0;
      end else if (mac_in && !mac_pend_q) begin
         mac_pend_d      = 1'b1;
         mac_pend_addr_d = bus.mac_addr;
      end

      if (flush || cpu_take) begin
         cpu_pend_d = 1'b0;
      end else if (cpu_in && !cpu_pend_q) begin
         cpu_pend_d      = 1'b1;
         cpu_pend_addr_d = bus.cpu_addr;
         cpu_pend_ok_d   = cpu_in_ok;
      end
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         beat_q          <= '0;
         ok_q            <= 1'b0;
         cpu_pend_q      <= 1'b0;
         cpu_pend_addr_q <= '0;
         cpu_pend_ok_q   <= 1'b0;
         mac_pend_q      <= 1'b0;
         mac_pend_addr_q <= '0;
         viol_q          <= 1'b0;
         rst_cnt_q       <= '0;
         mac_valid_q     <= 1'b0;
         mac_done_q      <= 1'b0;
         safe_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         beat_q          <= beat_d;
         ok_q            <= ok_d;
         cpu_pend_q      <= cpu_pend_d;
         cpu_pend_addr_q <= cpu_pend_addr_d;
         cpu_pend_ok_q   <= cpu_pend_ok_d;
         mac_pend_q      <= mac_pend_d;
         mac_pend_addr_q <= mac_pend_addr_d;
         viol_q          <= viol_d;
         rst_cnt_q       <= rst_cnt_d;
         mac_valid_q     <= mac_valid_d;
         mac_done_q      <= mac_done_d;
         safe_q          <= safe_d;
      end
   end

   assign mem_rd_w       = (state_q == MAC_RD) || (state_q == CPU_RD);
   assign bus.mem_rd     = mem_rd_w;
   assign bus.mem_addr   = mem_rd_w ? addr_q : '0;
   assign bus.cpu_ack    = (state_q == CPU_ACK);
   assign bus.cpu_rdata  = ((state_q == CPU_ACK) && ok_q) ? bus.mem_dout : 16'h0000;
   assign bus.mac_valid  = mac_valid_q;
   assign bus.mac_done   = mac_done_q;
   assign bus.mac_rdata  = mac_valid_q ? bus.mem_dout : 16'h0000;
   assign in_safe_area   = safe_q;
   assign violation      = viol_q;
   assign reset          = flush;
endmodule

// File: tb/tb_smart_key_arbiter.sv
// Directed bench for smart_key_arbiter with a behavioural synchronous-read key ROM.
// Reset-pulse expectations follow SMART_VIOLATION_RESET_EN when it is defined for the build.
module tb_smart_key_arbiter;
`ifdef SMART_VIOLATION_RESET_EN
   localparam bit RST_EN = 1'b1;
`else
   localparam bit RST_EN = 1'b0;
`endif

   logic        mclk;
   logic        reset_n;
   logic [15:0] ins_addr;
   logic        in_safe_area;
   logic        violation;
   logic        reset;
   int          n_total = 0;
   int          n_bad   = 0;
   logic [15:0] mem [32];

   smart_key_arbiter_if #(.SIZE_MEM_ADDR(5)) bus ();

   smart_key_arbiter dut (
      .mclk         (mclk),
      .reset_n      (reset_n),
      .bus          (bus),
      .ins_addr     (ins_addr),
      .in_safe_area (in_safe_area),
      .violation    (violation),
      .reset        (reset)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   always @(posedge mclk) begin
      if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_addr];
   end

   function automatic logic [15:0] exp_mem(input int a);
      return (a == 3) ? 16'hBEEF : 16'hA000 + 16'(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic cpu_allowed(input logic [15:0] ia, input logic [4:0] a);
      ins_addr     = ia;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = a;
      step();
      bus.cpu_req  = 1'b0;
      check("ok_rd_k1", 32'(bus.mem_rd), 1);
      check("ok_addr_k1", 32'(bus.mem_addr), 32'(a));
      check("ok_ack_k1", 32'(bus.cpu_ack), 0);
      step();
      check("ok_ack_k2", 32'(bus.cpu_ack), 1);
      check("ok_data_k2", 32'(bus.cpu_rdata), 32'(exp_mem(int'(a))));
      check("ok_rd_k2", 32'(bus.mem_rd), 0);
      $display("txn cpu_read ins=%0d addr=%0d data=%h", ia, a, bus.cpu_rdata);
      step();
      check("ok_ack_k3", 32'(bus.cpu_ack), 0);
      check("ok_data_k3", 32'(bus.cpu_rdata), 0);
      check("ok_viol", 32'(violation), 0);
      step();
   endtask

   task automatic cpu_denied(input logic [15:0] ia, input logic [4:0] a);
      ins_addr     = ia;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = a;
      step();
      bus.cpu_req  = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         check("deny_rd", 32'(bus.mem_rd), 0);
         check("deny_ack", 32'(bus.cpu_ack), 32'(c == 2));
         check("deny_data", 32'(bus.cpu_rdata), 0);
         check("deny_viol", 32'(violation), 1);
         check("deny_reset", 32'(reset), 32'(RST_EN && c <= 4));
         step();
      end
      $display("txn cpu_deny ins=%0d addr=%0d violation=%0b", ia, a, violation);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = exp_mem(i);
      reset_n       = 1'b0;
      ins_addr      = 16'd0;
      bus.cpu_req   = 1'b0;
      bus.cpu_addr  = '0;
      bus.mac_start = 1'b0;
      bus.mac_addr  = '0;
      step();
      step();
      check("rst_outs", {16'(bus.mem_addr), 8'(bus.mem_rd), 1'b0, bus.cpu_ack, bus.mac_valid,
                         bus.mac_done, in_safe_area, violation, reset, 1'b0}, 0);
      check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
      check("rst_mac_rdata", 32'(bus.mac_rdata), 0);
      reset_n = 1'b1;

      ins_addr = 16'd29; step(); check("safe_29", 32'(in_safe_area), 1);
      ins_addr = 16'd30; step(); check("safe_30", 32'(in_safe_area), 0);
      ins_addr = 16'd20; step(); check("safe_20", 32'(in_safe_area), 1);
      $display("txn safe_area boundaries checked");

      cpu_allowed(16'd20, 5'd3);
      cpu_allowed(16'd16, 5'd5);
      cpu_allowed(16'd31, 5'd17);

      // MAC burst wrapping past the top of memory
      bus.mac_start = 1'b1;
      bus.mac_addr  = 5'd30;
      step();
      bus.mac_start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         int ra;
         int va;
         ra = (29 + c) % 32;
         va = (28 + c) % 32;
         check("wrap_rd", 32'(bus.mem_rd), 32'(c <= 8));
         check("wrap_addr", 32'(bus.mem_addr), (c <= 8) ? ra : 0);
         check("wrap_valid", 32'(bus.mac_valid), 32'(c >= 2 && c <= 9));
         check("wrap_data", 32'(bus.mac_rdata), (c >= 2 && c <= 9) ? 32'(exp_mem(va)) : 0);
         check("wrap_done", 32'(bus.mac_done), 32'(c == 9));
         step();
      end
      $display("txn mac_burst start=30 len=8");

      // MAC and CPU in the same cycle: burst first, one idle cycle, then CPU
      ins_addr      = 16'd20;
      bus.mac_start = 1'b1;
      bus.mac_addr  = 5'd0;
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = 5'd3;
      step();
      bus.mac_start = 1'b0;
      bus.cpu_req   = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         check("sim_rd", 32'(bus.mem_rd), 32'(c <= 8 || c == 10));
         check("sim_addr", 32'(bus.mem_addr), (c <= 8) ? c - 1 : ((c == 10) ? 3 : 0));
         check("sim_ack", 32'(bus.cpu_ack), 32'(c == 11));
         check("sim_data", 32'(bus.cpu_rdata), (c == 11) ? 32'h0000BEEF : 0);
         step();
      end
      $display("txn simultaneous mac+cpu");

      cpu_denied(16'd32, 5'd8);
      cpu_denied(16'd0, 5'd8);

      // asynchronous reset in the 3rd burst cycle with a CPU read pending
      bus.mac_start = 1'b1;
      bus.mac_addr  = 5'd4;
      step();
      bus.mac_start = 1'b0;
      ins_addr      = 16'd20;
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = 5'd3;
      step();
      bus.cpu_req   = 1'b0;
      step();
      check("mid_rd_before", 32'(bus.mem_rd), 1);
      reset_n = 1'b0;
      #1;
      check("mid_rd", 32'(bus.mem_rd), 0);
      check("mid_addr", 32'(bus.mem_addr), 0);
      check("mid_valid", 32'(bus.mac_valid), 0);
      check("mid_viol", 32'(violation), 0);
      check("mid_safe", 32'(in_safe_area), 0);
      step();
      step();
      reset_n = 1'b1;
      begin
         int hits;
         hits = 0;
         for (int c = 0; c < 12; c++) begin
            hits += int'(bus.mem_rd) + int'(bus.mac_valid) + int'(bus.mac_done) + int'(bus.cpu_ack);
            step();
         end
         check("mid_after_quiet", 32'(hits), 0);
      end
      $display("txn reset_mid_burst");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/smart_key_arbiter.md
# smart_key_arbiter

Sequencer and arbiter for the SMART key memory port. It shares one synchronous-read key memory between two requesters: the MAC engine, which issues burst key reads, and the CPU, which issues single-word reads. CPU reads are allowed only while the current instruction address is inside the trusted code region. A disallowed CPU read never reaches memory and raises a violation. The block sits between the openMSP430 core, the MAC datapath and the key ROM.

## Interface
- SIZE_MEM_ADDR, 5: key memory address width in bits.
- LOW_CODE, 16: first trusted instruction address (inclusive).
- HIGH_CODE, 32: end of the trusted code region (exclusive).
- LOW_SAFE, 20: first safe-area address (inclusive).
- HIGH_SAFE, 30: end of the safe area (exclusive).
- MAC_BURST, 8: words per MAC burst; legal range 1..2^SIZE_MEM_ADDR.
- RESET_CYCLES, 4: width of the violation reset pulse, in cycles.

- mclk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ins_addr  in  16  current CPU instruction address.
- cpu_req  in  1  one-cycle pulse requesting a CPU key read.
- cpu_addr  in  SIZE_MEM_ADDR  CPU read address; captured with cpu_req.
- cpu_rdata  out  16  CPU read data; valid while cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse for a CPU read.
- mac_start  in  1  one-cycle pulse requesting a MAC burst.
- mac_addr  in  SIZE_MEM_ADDR  burst start address; captured with mac_start.
- mac_rdata  out  16  MAC burst data word.
- mac_valid  out  1  high for each valid mac_rdata word.
- mac_done  out  1  high together with the last mac_valid of a burst.
- mem_addr  out  SIZE_MEM_ADDR  key memory address.
- mem_rd  out  1  key memory read strobe.
- mem_dout  in  16  key memory data; valid one cycle after mem_rd.
- in_safe_area  out  1  registered flag: LOW_SAFE <= ins_addr < HIGH_SAFE.
- violation  out  1  sticky flag for a disallowed CPU access.
- reset  out  1  active-high reset request to the CPU.

## Operation
- FSM states and transitions:
  - IDLE → MAC_RD when a MAC start is present; MAC has priority.
  - IDLE → CPU_RD when a CPU request is present and allowed.
  - IDLE → CPU_DENY when a CPU request is present and not allowed.
  - MAC_RD → IDLE after the MAC_BURST-th read is issued.
  - CPU_RD → CPU_ACK → IDLE.
  - CPU_DENY → CPU_ACK → IDLE.
- Pending registers:
  - One CPU entry and one MAC entry; each holds the captured address.
  - A pulse that arrives while the block is busy is held in its entry.
  - A second pulse on an already-full entry is dropped.
  - A mac_start that arrives while a burst is in progress is dropped.
- CPU permission check:
  - Allowed when LOW_CODE <= ins_addr < HIGH_CODE.
  - ins_addr is sampled in the cycle the request is pulsed, not when it is serviced.
  - The allowed/denied result is stored with the pending entry.
- MAC_RD:
  - mem_rd is high for MAC_BURST consecutive cycles.
  - mem_addr starts at the captured address and increments each cycle, wrapping modulo 2^SIZE_MEM_ADDR.
  - A CPU request that arrives during a burst is serviced after the burst ends.
- CPU_DENY:
  - mem_rd stays low; the memory is never accessed.
  - cpu_rdata returns 16'h0000 with cpu_ack.
  - violation is set and is cleared only by reset_n.
- When both pending entries are valid in IDLE, the MAC burst runs first, then the CPU read.
- Outputs when idle:
  - mem_rd is 0 and mem_addr is 0.
  - cpu_rdata and mac_rdata are 0 whenever their valid or ack signal is low.
- Reset values: every output is 0; the FSM is in IDLE; both pending entries are empty; the violation reset counter is 0.
- reset_n asserted mid-operation aborts immediately: a burst in progress ends with no mac_done and both pending entries are cleared.

## Timing
- CPU read accepted in IDLE at edge k:
  - mem_rd and mem_addr are driven in cycle k+1.
  - cpu_ack and cpu_rdata (mem_dout) appear in cycle k+2 for one cycle.
- Denied CPU request: the same k+2 ack timing, with data 0.
- MAC burst accepted at edge k:
  - mem_rd is high in cycles k+1 .. k+MAC_BURST.
  - mac_valid is high in cycles k+2 .. k+MAC_BURST+1.
  - mac_done is high in cycle k+MAC_BURST+1.
- After a burst or a CPU_ACK, one IDLE cycle precedes servicing of the next pending request.
- in_safe_area lags ins_addr by one cycle.

## Configuration
- SMART_VIOLATION_RESET_EN defined:
  - A denial asserts reset for RESET_CYCLES cycles, starting the cycle after the denied request is sampled.
  - While reset is high, both pending entries are flushed and new mac_start/cpu_req pulses are ignored.
- SMART_VIOLATION_RESET_EN undefined:
  - reset is tied to 0.
  - A denial only sets violation and zeroes the returned data; operation continues normally.

## Test plan
- Allowed CPU read: ins_addr=20, cpu_req with cpu_addr=3, mem[3]=16'hBEEF -> mem_rd high in k+1, cpu_ack with cpu_rdata=16'hBEEF in k+2, violation stays 0.
- Denied CPU read: ins_addr=0, cpu_req with cpu_addr=8 -> mem_rd never high, cpu_ack with data 0 in k+2, violation=1. With the macro: reset high for exactly 4 cycles. Without it: reset stays 0.
- MAC wrap-around: mac_start with mac_addr=30, MAC_BURST=8 -> mem_addr sequence 30,31,0,1,2,3,4,5; 8 mac_valid pulses; mac_done with the 8th.
- Simultaneous requests: mac_start and allowed cpu_req in the same cycle -> full burst first; CPU mem_rd one cycle after the last MAC mem_rd plus one IDLE cycle; cpu_ack follows.
- Boundaries: ins_addr=16 allowed, ins_addr=32 denied; ins_addr=30 gives in_safe_area=0, ins_addr=29 gives in_safe_area=1.
- Reset mid-burst: reset_n low in the 3rd burst cycle -> all outputs 0 asynchronously, no mac_done, pending CPU request discarded after reset_n releases.
